link_dataflow_scheduler: RTL



---
 rtl/link_dataflow_scheduler_pkg.sv | 21 ++
 rtl/link_dataflow_scheduler_if.sv | 31 +++
 rtl/link_dataflow_scheduler_rr_arbiter.sv | 37 +++
 rtl/link_dataflow_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/link_dataflow_scheduler_pkg.sv
// Shared types and constant helpers for the link-RAM dataflow scheduler.
package link_df_pkg;

  typedef enum logic [0:0] {
    SERVE = 1'b0,
    INIT  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Free-list terminator: all-ones at width w; callers cast down to their word width.
  function automatic logic [63:0] null_ptr(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/link_dataflow_scheduler_if.sv
// Request/return channels and link-RAM port bundled between controllers, scheduler and RAM.
interface link_dataflow_scheduler_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CH         = 2
);

  logic [CH-1:0]            ch_req_valid;
  logic [CH-1:0]            ch_req_ready;
  logic [CH-1:0]            ch_req_write;
  logic [CH*ADDR_WIDTH-1:0] ch_req_addr;
  logic [CH*DATA_WIDTH-1:0] ch_req_wdata;
  logic [CH-1:0]            ch_rd_valid;
  logic [DATA_WIDTH-1:0]    ch_rd_data;
  logic                     ram_en;
  logic                     ram_we;
  logic [ADDR_WIDTH-1:0]    ram_addr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  modport master (
    output ch_req_valid, ch_req_write, ch_req_addr, ch_req_wdata, ram_rdata,
    input  ch_req_ready, ch_rd_valid, ch_rd_data, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  ch_req_valid, ch_req_write, ch_req_addr, ch_req_wdata, ram_rdata,
    output ch_req_ready, ch_rd_valid, ch_rd_data, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/link_dataflow_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid channel after last_grant, wrapping at CH.
module link_df_rr_arbiter
  import link_df_pkg::*;
#(
  parameter int CH = 2,
  localparam int IDW = clog2(CH)
) (
  input  logic [CH-1:0]  valid_i,
  input  logic [IDW-1:0] last_grant_i,
  output logic [CH-1:0]  grant_o,
  output logic [IDW-1:0] id_o
);

  logic found;

  // Pass 1 covers channels above last_grant; pass 2 is the wrap back from ch0.
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (!found && valid_i[i] && (IDW'(i) > last_grant_i)) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        id_o       = IDW'(i);
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (!found && valid_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        id_o       = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/link_dataflow_scheduler.sv
// Round-robin CH->1 link-RAM scheduler with free-list init sweep (LINK_DF_INIT_EN); command 1 cycle after
// handshake, read return RD_LATENCY cycles later; ready is a combinational grant, held low during INIT.
module link_dataflow_scheduler
  import link_df_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int CH         = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_start,
  output logic init_busy,
  output logic init_done,
  link_dataflow_scheduler_if.slave bus
);

  localparam int IDW = clog2(CH);

  logic [CH-1:0]         grant;
  logic [CH-1:0]         ready;
  logic [CH-1:0]         rd_valid;
  logic [IDW-1:0]        grant_id;
  logic                  hs;
  logic                  serve;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  ram_en_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [IDW-1:0]        last_grant_q;
  logic [RD_LATENCY:0]   tag_vld_q;
  logic [IDW-1:0]        tag_id_q [RD_LATENCY+1];

`ifdef LINK_DF_INIT_EN
  localparam int KW = ADDR_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] NULL_PTR = DATA_WIDTH'(null_ptr(DATA_WIDTH));

  state_t                state_q;
  logic [KW-1:0]         k_q;
  logic [KW-1:0]         sweep_k;
  logic                  sweep_last;
  logic [DATA_WIDTH-1:0] sweep_wdata;
  logic                  init_done_q;

  assign serve     = (state_q == SERVE);
  assign init_busy = (state_q == INIT);
  assign init_done = init_done_q;

  // In SERVE the next sweep word is always entry 0 (used when init_start lands without a grant).
  always_comb begin
    sweep_k     = serve ? '0 : k_q;
    sweep_last  = (sweep_k == KW'(DEPTH - 1));
    sweep_wdata = sweep_last ? NULL_PTR : DATA_WIDTH'(sweep_k + KW'(1));
  end
`else
  logic unused_init;
  assign unused_init = init_start ^ (DEPTH < 0);
  assign serve       = 1'b1;
  assign init_busy   = 1'b0;
  assign init_done   = 1'b1;
`endif

  link_df_rr_arbiter #(.CH(CH)) u_arb (
    .valid_i      (bus.ch_req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .id_o         (grant_id)
  );

  assign ready = (serve && rst_n) ? grant : '0;
  assign hs    = |(bus.ch_req_valid & ready);

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) begin
        sel_we    = bus.ch_req_write[i];
        sel_addr  = bus.ch_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.ch_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      last_grant_q <= IDW'(CH - 1);
`ifdef LINK_DF_INIT_EN
      state_q      <= SERVE;
      k_q          <= '0;
      init_done_q  <= 1'b0;
`endif
    end else begin
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      if (hs) begin
        ram_en_q     <= 1'b1;
        ram_we_q     <= sel_we;
        ram_addr_q   <= sel_addr;
        ram_wdata_q  <= sel_wdata;
        last_grant_q <= grant_id;
      end
`ifdef LINK_DF_INIT_EN
      case (state_q)
        SERVE: begin
          if (init_start) begin
            state_q     <= INIT;
            init_done_q <= 1'b0;
            // A grant in the start cycle owns the next port slot; the sweep slips by one.
            if (hs) begin
              k_q <= '0;
            end else begin
              ram_en_q    <= 1'b1;
              ram_we_q    <= 1'b1;
              ram_addr_q  <= ADDR_WIDTH'(sweep_k);
              ram_wdata_q <= sweep_wdata;
              k_q         <= KW'(1);
            end
          end
        end
        INIT: begin
          if (k_q == KW'(DEPTH)) begin
            state_q     <= SERVE;
            init_done_q <= 1'b1;
          end else begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= ADDR_WIDTH'(sweep_k);
            ram_wdata_q <= sweep_wdata;
            k_q         <= k_q + KW'(1);
          end
        end
      endcase
`endif
    end
  end

  // Stage 0 rides alongside the RAM command; stage RD_LATENCY lines up with ram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[RD_LATENCY-1:0], hs & ~sel_we};
      tag_id_q[0] <= grant_id;
      for (int i = 1; i <= RD_LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < CH; i++) begin
      rd_valid[i] = tag_vld_q[RD_LATENCY] && (tag_id_q[RD_LATENCY] == IDW'(i));
    end
  end

  assign bus.ch_req_ready = ready;
  assign bus.ch_rd_valid  = rd_valid;
  assign bus.ch_rd_data   = tag_vld_q[RD_LATENCY] ? bus.ram_rdata : '0;
  assign bus.ram_en       = ram_en_q;
  assign bus.ram_we       = ram_we_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;

endmodule
